alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand/instruction/PC width.
REQ-002 clk  input  1  rising-edge clock, sole clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream instruction bundle valid.
REQ-005 in_ready  output  1  stage can accept a bundle this cycle.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 pc  input  DATA_WIDTH  instruction address.
REQ-008 rs1_data / rs2_data  input  DATA_WIDTH each  register-file read values.
REQ-009 flush  input  1  discard all held and incoming bundles.
REQ-010 out_valid  output  1  issued bundle valid toward ALU.
REQ-011 out_ready  input  1  downstream accepts bundle.
REQ-012 alu_op1 / alu_op2  output  DATA_WIDTH each  ALU operands (ALUop1/ALUop2).
REQ-013 alu_ctrl  output  8  ALU opcode; bits [7:4] always 0.
REQ-014 rd_addr  output  5  destination register; reg_write  output  1  writeback enable.
REQ-015 illegal  output  1  bundle carries unsupported encoding.

Function
REQ-016 Decode SHALL be combinational on the input side; results SHALL be registered, giving 1-cycle latency from accepted input to out_valid.
REQ-017 Transfer SHALL occur on in_valid&&in_ready (input) and out_valid&&out_ready (output); the stage SHALL hold outputs stable while out_valid&&!out_ready.
REQ-018 Storage SHALL be an output register plus one skid register; in_ready SHALL be a registered signal equal to "skid empty".
REQ-019 States: EMPTY (no bundle), ONE (output reg full), TWO (output+skid full); EMPTY->ONE on input; ONE->TWO on input with out stalled; TWO->ONE on output; ONE->EMPTY on output without input; simultaneous in/out in ONE stays ONE with new bundle.
REQ-020 In TWO, on output acceptance the skid contents SHALL move to the output register in the same edge, skid order preserved (FIFO).
REQ-021 alu_ctrl encodings: ADD 0x00, SUB 0x01, AND 0x02, OR 0x03, XOR 0x04, SLL 0x05, SRL 0x06, SRA 0x07, SRAI 0x08, SLT 0x09, SLTU 0x0A, PASS 0x0B.
REQ-022 OP (0110011): op1=rs1_data, op2=rs2_data; SUB when funct3=000 and funct7=0100000; SRA when funct3=101 and funct7=0100000.
REQ-023 OP-IMM (0010011): op1=rs1_data, op2=sign-extended instr[31:20]; SLLI/SRLI/SRAI SHALL use op2={27'b0,instr[24:20]}; SRAI SHALL use 0x08.
REQ-024 LUI (0110111): op2={instr[31:12],12'b0}, ctrl PASS, op1=0.
REQ-025 AUIPC (0010111): op1=pc, op2={instr[31:12],12'b0}, ctrl ADD.
REQ-026 rd_addr=instr[11:7]; reg_write=1 for all legal decoded bundles with rd!=0, else 0.
REQ-027 flush SHALL, on the next edge, clear out_valid, empty the skid, set in_ready=1, and ignore any same-cycle input (flush wins over in_valid and out_ready).

Reset
REQ-028 While rst_n=0: out_valid=0, in_ready=0, skid empty, alu_op1=alu_op2=0, alu_ctrl=0, rd_addr=0, reg_write=0, illegal=0.
REQ-029 in_ready SHALL rise on the first clk edge after rst_n deasserts; reset mid-transfer SHALL drop all held bundles.

Configuration
REQ-030 Macro ALU_ISSUE_ILLEGAL_EN: when defined, unsupported opcodes or funct7 values SHALL issue with illegal=1, reg_write=0, alu_ctrl=ADD, operands 0.
REQ-031 Without ALU_ISSUE_ILLEGAL_EN, illegal SHALL be tied 0 and unsupported encodings SHALL be dropped (accepted, not issued).

Verification
REQ-032 Reset then instr=0x00B50533 (add a0,a0,a1), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, ctrl 0x00, op1=5, op2=7, rd=10, reg_write=1.
REQ-033 instr=0x4020D093 (srai x1,x1,2), rs1=0x80000000 -> ctrl 0x08, op2=2; instr=0x00001537 (lui a0,1) -> ctrl 0x0B, op2=0x00001000.
REQ-034 out_ready=0, three back-to-back inputs A,B,C -> A in output, B in skid, in_ready=0, C held; raise out_ready -> A,B,C issued in order, no loss or duplicate.
REQ-035 State TWO with flush=1 and in_valid=1 same cycle -> next cycle out_valid=0, in_ready=1, incoming bundle not issued.
REQ-036 With ALU_ISSUE_ILLEGAL_EN, instr=0xFFFFFFFF -> illegal=1, reg_write=0; without macro -> no out_valid pulse.
REQ-037 rst_n pulsed low asynchronously in state TWO mid-cycle -> outputs reach reset values before next clk edge.

Source files
------------

// File: rtl/alu_issue_stage.sv
// RV32I ALU issue stage: combinational decode into a 2-entry output/skid buffer.
// Optional macro ALU_ISSUE_ILLEGAL_EN issues unsupported encodings flagged illegal instead of dropping them.
module alu_issue_stage #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [7:0]            alu_ctrl,
  output logic [4:0]            rd_addr,
  output logic                  reg_write,
  output logic                  illegal
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] C_ADD  = 4'h0;
  localparam logic [3:0] C_SUB  = 4'h1;
  localparam logic [3:0] C_AND  = 4'h2;
  localparam logic [3:0] C_OR   = 4'h3;
  localparam logic [3:0] C_XOR  = 4'h4;
  localparam logic [3:0] C_SLL  = 4'h5;
  localparam logic [3:0] C_SRL  = 4'h6;
  localparam logic [3:0] C_SRA  = 4'h7;
  localparam logic [3:0] C_SRAI = 4'h8;
  localparam logic [3:0] C_SLT  = 4'h9;
  localparam logic [3:0] C_SLTU = 4'hA;
  localparam logic [3:0] C_PASS = 4'hB;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic [3:0]            ctrl;
    logic [4:0]            rd;
    logic                  wr;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic                  ill;
`endif
  } bundle_t;

  logic [1:0]            state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  bundle_t               out_q, out_d;
  bundle_t               skid_q, skid_d;

  logic [6:0]            opcode;
  logic [6:0]            funct7;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_u;
  logic [DATA_WIDTH-1:0] shamt;
  logic                  unused_rs_fields;

  bundle_t               dec;
  logic                  dec_ok;
  logic                  issue_ok;
  logic                  accept;
  logic                  push;
  logic                  pop;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = DATA_WIDTH'($signed(instr[31:20]));
  assign imm_u  = DATA_WIDTH'($signed({instr[31:12], 12'b0}));
  assign shamt  = DATA_WIDTH'(instr[24:20]);
  assign unused_rs_fields = ^instr[19:15];

  // funct3 -> ALU op; alt selects SUB/SRA where funct7 distinguishes them
  function automatic logic [3:0] f3_ctrl(input logic [2:0] f3, input logic alt);
    logic [3:0] c;
    case (f3)
      3'b000:  c = alt ? C_SUB : C_ADD;
      3'b001:  c = C_SLL;
      3'b010:  c = C_SLT;
      3'b011:  c = C_SLTU;
      3'b100:  c = C_XOR;
      3'b101:  c = alt ? C_SRA : C_SRL;
      3'b110:  c = C_OR;
      default: c = C_AND;
    endcase
    return c;
  endfunction

  always_comb begin
    dec    = '0;
    dec_ok = 1'b0;
    dec.rd = instr[11:7];
    case (opcode)
      OPC_OP: begin
        dec.op1 = rs1_data;
        dec.op2 = rs2_data;
        if (funct7 == F7_BASE) begin
          dec_ok   = 1'b1;
          dec.ctrl = f3_ctrl(funct3, 1'b0);
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec_ok   = 1'b1;
          dec.ctrl = f3_ctrl(funct3, 1'b1);
        end
      end
      OPC_OPIMM: begin
        dec.op1 = rs1_data;
        case (funct3)
          3'b001: begin
            dec.op2  = shamt;
            dec.ctrl = C_SLL;
            dec_ok   = (funct7 == F7_BASE);
          end
          3'b101: begin
            dec.op2  = shamt;
            dec.ctrl = (funct7 == F7_ALT) ? C_SRAI : C_SRL;
            dec_ok   = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          default: begin
            dec.op2  = imm_i;
            dec.ctrl = f3_ctrl(funct3, 1'b0);
            dec_ok   = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        dec.op2  = imm_u;
        dec.ctrl = C_PASS;
        dec_ok   = 1'b1;
      end
      OPC_AUIPC: begin
        dec.op1  = pc;
        dec.op2  = imm_u;
        dec.ctrl = C_ADD;
        dec_ok   = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
    dec.wr = dec_ok && (instr[11:7] != 5'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
    if (!dec_ok) begin
      dec.op1  = '0;
      dec.op2  = '0;
      dec.ctrl = C_ADD;
      dec.ill  = 1'b1;
    end
`endif
  end

`ifdef ALU_ISSUE_ILLEGAL_EN
  assign issue_ok = 1'b1;
`else
  assign issue_ok = dec_ok;
`endif

  // Unsupported bundles without the illegal feature are accepted but never enter the buffer.
  assign accept = in_valid && in_ready_q && !flush;
  assign push   = accept && issue_ok;
  assign pop    = (state_q != ST_EMPTY) && out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            out_d   = dec;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          case ({push, pop})
            2'b10: begin
              skid_d  = dec;
              state_d = ST_TWO;
            end
            2'b11:   out_d   = dec;
            2'b01:   state_d = ST_EMPTY;
            default: state_d = ST_ONE;
          endcase
        end
        ST_TWO: begin
          if (pop) begin
            out_d   = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign alu_op1   = out_q.op1;
  assign alu_op2   = out_q.op2;
  assign alu_ctrl  = {4'b0000, out_q.ctrl};
  assign rd_addr   = out_q.rd;
  assign reg_write = out_q.wr;
`ifdef ALU_ISSUE_ILLEGAL_EN
  assign illegal   = out_q.ill;
`else
  assign illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: decode vector table, scoreboard monitor, skid/flush/reset sequences.
module tb_alu_issue_stage;

  localparam int DW = 32;
`ifdef ALU_ISSUE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    bit          issue;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [7:0]  ctrl;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } vec_t;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [7:0]  ctrl;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   instr = '0;
  logic [DW-1:0] pc = '0;
  logic [DW-1:0] rs1_data = '0;
  logic [DW-1:0] rs2_data = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] alu_op1;
  logic [DW-1:0] alu_op2;
  logic [7:0]    alu_ctrl;
  logic [4:0]    rd_addr;
  logic          reg_write;
  logic          illegal;

  int   tests = 0;
  int   failed = 0;
  exp_t sb[$];
  vec_t vt[$];

  alu_issue_stage #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op1   (alu_op1),
    .alu_op2   (alu_op2),
    .alu_ctrl  (alu_ctrl),
    .rd_addr   (rd_addr),
    .reg_write (reg_write),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1,
                              input logic [31:0] r2, input bit iss, input logic [31:0] o1,
                              input logic [31:0] o2, input logic [7:0] c, input logic [4:0] rd,
                              input logic rw, input logic il);
    vec_t v;
    v.instr = i;  v.pc = p;   v.rs1 = r1; v.rs2 = r2; v.issue = iss;
    v.op1 = o1;   v.op2 = o2; v.ctrl = c; v.rd = rd;  v.rw = rw; v.ill = il;
    return v;
  endfunction

  function automatic exp_t exp_of(input vec_t v);
    return {v.op1, v.op2, v.ctrl, v.rd, v.rw, v.ill};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    instr    = v.instr;
    pc       = v.pc;
    rs1_data = v.rs1;
    rs2_data = v.rs2;
    in_valid = 1'b1;
  endtask

  task automatic send(input int idx, input bit rnd);
    int n;
    n = 0;
    drive(vt[idx]);
    if (rnd) out_ready = 1'($urandom_range(0, 1));
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        tests++;
        failed++;
        $display("FAIL accept_timeout actual=in_ready_low required=accept_within_50");
        break;
      end
      @(posedge clk);
      #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    if (vt[idx].issue) sb.push_back(exp_of(vt[idx]));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_remaining", 96'(sb.size()), 96'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Fill output and skid from EMPTY with the downstream stalled.
  task automatic load2(input int a, input int b);
    out_ready = 1'b0;
    drive(vt[a]);
    sb.push_back(exp_of(vt[a]));
    @(posedge clk);
    #1;
    drive(vt[b]);
    sb.push_back(exp_of(vt[b]));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    //           instr         pc           rs1          rs2         iss     op1          op2          ctrl   rd     rw    ill
    vt.push_back(mk(32'h00B50533, 32'h0,     32'd5,       32'd7,      1'b1,   32'd5,       32'd7,       8'h00, 5'd10, 1'b1, 1'b0));
    vt.push_back(mk(32'h4020D093, 32'h0,     32'h80000000,32'h55,     1'b1,   32'h80000000,32'd2,       8'h08, 5'd1,  1'b1, 1'b0));
    vt.push_back(mk(32'h00001537, 32'h0,     32'hDEAD,    32'hBEEF,   1'b1,   32'h0,       32'h00001000,8'h0B, 5'd10, 1'b1, 1'b0));
    vt.push_back(mk(32'h402081B3, 32'h0,     32'd100,     32'd30,     1'b1,   32'd100,     32'd30,      8'h01, 5'd3,  1'b1, 1'b0));
    vt.push_back(mk(32'hFFF00293, 32'h0,     32'h10,      32'h0,      1'b1,   32'h10,      32'hFFFFFFFF,8'h00, 5'd5,  1'b1, 1'b0));
    vt.push_back(mk(32'h12345397, 32'h100,   32'h77,      32'h0,      1'b1,   32'h100,     32'h12345000,8'h00, 5'd7,  1'b1, 1'b0));
    vt.push_back(mk(32'h00208033, 32'h0,     32'd1,       32'd2,      1'b1,   32'd1,       32'd2,       8'h00, 5'd0,  1'b0, 1'b0));
    vt.push_back(mk(32'h0020B233, 32'h0,     32'd3,       32'd4,      1'b1,   32'd3,       32'd4,       8'h0A, 5'd4,  1'b1, 1'b0));
    vt.push_back(mk(32'h4020D333, 32'h0,     32'hF0000000,32'd4,      1'b1,   32'hF0000000,32'd4,       8'h07, 5'd6,  1'b1, 1'b0));
    vt.push_back(mk(32'h0F00F413, 32'h0,     32'hFF,      32'h0,      1'b1,   32'hFF,      32'hF0,      8'h02, 5'd8,  1'b1, 1'b0));
    vt.push_back(mk(32'h0040D493, 32'h0,     32'h80,      32'h0,      1'b1,   32'h80,      32'd4,       8'h06, 5'd9,  1'b1, 1'b0));
    vt.push_back(mk(32'h0020C533, 32'h0,     32'hA,       32'hC,      1'b1,   32'hA,       32'hC,       8'h04, 5'd10, 1'b1, 1'b0));
    vt.push_back(mk(32'hFFFFFFFF, 32'h0,     32'd9,       32'd9,      ILL_EN, 32'h0,       32'h0,       8'h00, 5'd31, 1'b0, 1'b1));
    vt.push_back(mk(32'h022080B3, 32'h0,     32'd1,       32'd2,      ILL_EN, 32'h0,       32'h0,       8'h00, 5'd1,  1'b0, 1'b1));
    vt.push_back(mk(32'h80000037, 32'h0,     32'h5,       32'h6,      1'b1,   32'h0,       32'h80000000,8'h0B, 5'd0,  1'b0, 1'b0));
    vt.push_back(mk(32'h01F09113, 32'h0,     32'd1,       32'h0,      1'b1,   32'd1,       32'd31,      8'h05, 5'd2,  1'b1, 1'b0));

    fork
      forever begin : monitor
        exp_t got;
        exp_t e;
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
          got = {alu_op1, alu_op2, alu_ctrl, rd_addr, reg_write, illegal};
          tests++;
          if (sb.size() == 0) begin
            failed++;
            $display("FAIL unexpected_issue actual=%h required=none", got);
          end else begin
            e = sb.pop_front();
            if (got !== e) begin
              failed++;
              $display("FAIL issue_bundle actual=%h required=%h", got, e);
            end
          end
        end
      end
    join_none

    #1 rst_n = 1'b0;
    #1 chk("reset_outputs", 96'({out_valid, in_ready, alu_op1, alu_op2, alu_ctrl, rd_addr, reg_write, illegal}), 96'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("in_ready_before_edge", 96'(in_ready), 96'(0));
    @(posedge clk);
    #1 chk("in_ready_after_reset", 96'(in_ready), 96'(1));

    // add a0,a0,a1: one-cycle latency to out_valid
    out_ready = 1'b1;
    drive(vt[0]);
    sb.push_back(exp_of(vt[0]));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("add_latency", 96'({out_valid, alu_ctrl, alu_op1, alu_op2, rd_addr, reg_write}),
        96'({1'b1, 8'h00, 32'd5, 32'd7, 5'd10, 1'b1}));
    drain();

    foreach (vt[i]) send(i, 1'b0);
    drain();
    for (int unsigned r = 0; r < 3; r++) begin
      foreach (vt[i]) send(i, 1'b1);
    end
    drain();

    // all-ones word in isolation: issued-as-illegal or silently dropped
    out_ready = 1'b1;
    send(12, 1'b0);
`ifdef ALU_ISSUE_ILLEGAL_EN
    chk("illegal_issue", 96'({out_valid, illegal, reg_write}), 96'(3'b110));
`else
    chk("illegal_dropped", 96'({out_valid, illegal}), 96'(2'b00));
    @(posedge clk);
    #1 chk("illegal_no_pulse", 96'(out_valid), 96'(0));
`endif
    drain();

    // three back-to-back bundles against a stalled output
    out_ready = 1'b0;
    drive(vt[3]);
    @(negedge clk);
    chk("skid_a_ready", 96'(in_ready), 96'(1));
    sb.push_back(exp_of(vt[3]));
    @(posedge clk);
    #1 drive(vt[4]);
    @(negedge clk);
    chk("skid_b_ready", 96'(in_ready), 96'(1));
    sb.push_back(exp_of(vt[4]));
    @(posedge clk);
    #1 drive(vt[5]);
    @(negedge clk);
    chk("skid_full", 96'({in_ready, out_valid, alu_op1, alu_ctrl}), 96'({1'b0, 1'b1, 32'd100, 8'h01}));
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("c_held", 96'({in_ready, out_valid, alu_op1}), 96'({1'b0, 1'b1, 32'd100}));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(5, 1'b0);
    drain();

    // flush in TWO beats a same-cycle input
    load2(7, 8);
    chk("two_before_flush", 96'({in_ready, out_valid, alu_ctrl}), 96'({1'b0, 1'b1, 8'h0A}));
    drive(vt[9]);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("flush_state", 96'({out_valid, in_ready}), 96'(2'b01));
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("flush_no_issue", 96'(out_valid), 96'(0));

    // flush in EMPTY with in_ready high still discards the input
    drive(vt[10]);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_beats_input", 96'({out_valid, in_ready}), 96'(2'b01));
    repeat (2) @(posedge clk);
    #1;

    // asynchronous reset mid-cycle while holding two bundles
    load2(11, 15);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_reset", 96'({out_valid, in_ready, alu_op1, alu_op2, alu_ctrl, rd_addr, reg_write, illegal}), 96'(0));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("in_ready_low_after_release", 96'(in_ready), 96'(0));
    @(posedge clk);
    #1 chk("in_ready_rises", 96'(in_ready), 96'(1));
    chk("no_bundle_after_reset", 96'(out_valid), 96'(0));
    send(1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
